uart_tx_arbiter: RTL and testbench

- Shares the single uart_tx byte transmitter between NUM_REQ on-chip requesters, e.g. command responder, capture dump engine and debug banner.
- Grants are packet-locked and round-robin: one requester holds the transmitter from its first byte through the byte flagged last.
- Sits between the requesters and uart_tx; its downstream side speaks the uart_tx tx_req/tx_ready/tx_data handshake.

---
 rtl/uart_tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter that shares one uart_tx byte transmitter between NUM_REQ requesters.
// Latency: 1-cycle arbitration in IDLE, then zero-latency pass-through. Backpressure: req_ready mirrors tx_ready for the grantee.
// Optional grantee-stall timeout with timeout_evt pulse: define UART_TX_ARBITER_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int MAX_PKT = 256,
  parameter int IDW     = 3
`ifdef UART_TX_ARBITER_TIMEOUT_EN
  , parameter int TIMEOUT = 1024
`endif
) (
  input  logic                 clk,
  input  logic                 reset_,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_req,
  input  logic                 tx_ready,
  output logic [7:0]           tx_data,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id
`ifdef UART_TX_ARBITER_TIMEOUT_EN
  , output logic               timeout_evt
`endif
);

  localparam int CW = $clog2(MAX_PKT) + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] gid_q, gid_d;
  logic [IDW-1:0] last_q, last_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           any_req;
  logic [IDW-1:0] pick;
  logic           g_req;
  logic           g_last;
  logic [7:0]     g_dat;
  logic           xfer;
  logic           pkt_done;
  logic           release_grant;

  // Searching from farthest to nearest lets the nearest set index after last_q win.
  always_comb begin
    pick    = '0;
    any_req = |req;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(last_q) + k) % NUM_REQ]) begin
        pick = IDW'((int'(last_q) + k) % NUM_REQ);
      end
    end
  end

  assign g_req    = req[gid_q];
  assign g_last   = req_last[gid_q];
  assign g_dat    = req_data[{gid_q, 3'b000} +: 8];
  assign xfer     = (state_q == BUSY) && g_req && tx_ready;
  assign pkt_done = xfer && (g_last || (cnt_q == CW'(MAX_PKT - 1)));

`ifdef UART_TX_ARBITER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] idle_q, idle_d;
  logic          evt_q;
  logic          to_hit;

  assign to_hit        = (state_q == BUSY) && !g_req && (idle_q == TW'(TIMEOUT - 1));
  assign release_grant = pkt_done || to_hit;
  assign timeout_evt   = evt_q;

  always_comb begin
    idle_d = idle_q;
    if (state_q == IDLE) begin
      idle_d = '0;
    end else if (release_grant || xfer) begin
      idle_d = '0;
    end else if (!g_req) begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      idle_q <= '0;
      evt_q  <= 1'b0;
    end else begin
      idle_q <= idle_d;
      evt_q  <= to_hit;
    end
  end
`else
  assign release_grant = pkt_done;
`endif

  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gid_d   = pick;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (xfer) begin
          cnt_d = cnt_q + 1'b1;
        end
        // grant_id deliberately keeps its value after release.
        if (release_grant) begin
          last_d  = gid_q;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_req    = 1'b0;
    tx_data   = 8'h00;
    req_ready = '0;
    if (state_q == BUSY) begin
      tx_req           = g_req;
      tx_data          = g_dat;
      req_ready[gid_q] = tx_ready;
    end
  end

  assign busy     = (state_q == BUSY);
  assign grant_id = gid_q;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= IDLE;
      gid_q   <= '0;
      last_q  <= IDW'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter against a packet-level reference model.
module tb_uart_tx_arbiter;

  localparam int NUM  = 3;
  localparam int MAXP = 4;
  localparam int IDW  = 2;
  localparam int TMO  = 16;

  logic             clk;
  logic             reset_;
  logic [NUM-1:0]   req;
  logic [8*NUM-1:0] req_data;
  logic [NUM-1:0]   req_last;
  logic [NUM-1:0]   req_ready;
  logic             tx_req;
  logic             tx_ready;
  logic [7:0]       tx_data;
  logic             busy;
  logic [IDW-1:0]   grant_id;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
  logic             timeout_evt;
`endif

  uart_tx_arbiter #(
    .NUM_REQ(NUM), .MAX_PKT(MAXP), .IDW(IDW)
`ifdef UART_TX_ARBITER_TIMEOUT_EN
    , .TIMEOUT(TMO)
`endif
  ) dut (
    .clk(clk), .reset_(reset_), .req(req), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_req(tx_req), .tx_ready(tx_ready), .tx_data(tx_data),
    .busy(busy), .grant_id(grant_id)
`ifdef UART_TX_ARBITER_TIMEOUT_EN
    , .timeout_evt(timeout_evt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester-side driver queues and independent expected-stream queues.
  logic [7:0] dq_dat[NUM][$];
  bit         dq_last[NUM][$];
  logic [7:0] eq_dat[NUM][$];
  bit         eq_last[NUM][$];
  bit         shown[NUM];
  bit         acc[NUM];
  bit         rdy_pat[$];
  int         dens;
  int         rdy_dens;

  // Reference model state.
  bit m_busy;
  int m_gid, m_last, m_cnt, m_idle;
  bit m_evt;
  int grants[$];
  int n_xfer;
  int n_evt;

  int checks;
  int errors;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push_byte(input int i, input logic [7:0] d, input bit l);
    dq_dat[i].push_back(d);
    dq_last[i].push_back(l);
    eq_dat[i].push_back(d);
    eq_last[i].push_back(l);
  endtask

  task automatic push_pkt(input int i, input int len);
    for (int b = 0; b < len; b++) push_byte(i, 8'($urandom_range(255)), b == len - 1);
  endtask

  task automatic model_release();
    m_last = m_gid;
    m_busy = 1'b0;
    m_cnt  = 0;
    m_idle = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < NUM; i++) begin
      if (acc[i]) begin
        void'(dq_dat[i].pop_front());
        void'(dq_last[i].pop_front());
        shown[i] = 1'b0;
        acc[i]   = 1'b0;
      end
      if (!shown[i] && dq_dat[i].size() > 0 && $urandom_range(99) < dens) shown[i] = 1'b1;
      req[i]           = shown[i];
      req_data[8*i+:8] = shown[i] ? dq_dat[i][0] : 8'h00;
      req_last[i]      = shown[i] ? dq_last[i][0] : 1'b0;
    end
    if (rdy_pat.size() > 0) tx_ready = rdy_pat.pop_front();
    else                    tx_ready = ($urandom_range(99) < rdy_dens);
  endtask

  task automatic check_cycle();
    logic [NUM-1:0] exp_rr;
    bit lst;
    exp_rr = '0;
    if (m_busy) exp_rr[m_gid] = tx_ready;
    chk("busy", busy, m_busy);
    chk("grant_id", grant_id, m_gid);
    chk("tx_req", tx_req, m_busy && req[m_gid]);
    chk("req_ready", req_ready, exp_rr);
`ifdef UART_TX_ARBITER_TIMEOUT_EN
    chk("timeout_evt", timeout_evt, m_evt);
    if (timeout_evt) n_evt++;
`endif
    m_evt = 1'b0;
    for (int i = 0; i < NUM; i++) acc[i] = req[i] && req_ready[i];
    if (!m_busy) begin
      if (|req) begin
        for (int k = 1; k <= NUM; k++) begin
          if (!m_busy && req[(m_last + k) % NUM]) begin
            m_gid  = (m_last + k) % NUM;
            m_busy = 1'b1;
          end
        end
        m_cnt  = 0;
        m_idle = 0;
        grants.push_back(m_gid);
      end
    end else if (req[m_gid] && tx_ready) begin
      if (eq_dat[m_gid].size() == 0) begin
        chk("unexpected_byte", 1, 0);
      end else begin
        chk("tx_data", tx_data, eq_dat[m_gid].pop_front());
        lst = eq_last[m_gid].pop_front();
        n_xfer++;
        m_cnt++;
        m_idle = 0;
        if (lst || m_cnt == MAXP) model_release();
      end
    end else if (!req[m_gid]) begin
`ifdef UART_TX_ARBITER_TIMEOUT_EN
      m_idle++;
      if (m_idle == TMO) begin
        model_release();
        m_evt = 1'b1;
      end
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1 drive();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic flush();
    for (int i = 0; i < NUM; i++) begin
      dq_dat[i].delete();  dq_last[i].delete();
      eq_dat[i].delete();  eq_last[i].delete();
      shown[i] = 1'b0;
      acc[i]   = 1'b0;
    end
    rdy_pat.delete();
    req = '0; req_data = '0; req_last = '0; tx_ready = 1'b1;
    m_busy = 1'b0; m_gid = 0; m_last = NUM - 1; m_cnt = 0; m_idle = 0; m_evt = 1'b0;
    grants.delete();
    n_xfer = 0;
    n_evt  = 0;
    dens = 100;
    rdy_dens = 100;
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    flush();
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
  endtask

  task automatic drain(input string tag);
    int  budget;
    bit  empty;
    budget = 0;
    empty  = 1'b0;
    while (!empty && budget < 2000) begin
      step();
      budget++;
      empty = !m_busy;
      for (int i = 0; i < NUM; i++) if (dq_dat[i].size() > 0 || eq_dat[i].size() > 0) empty = 1'b0;
    end
    chk({tag, "_drained"}, empty, 1'b1);
  endtask

  // seq holds the expected grant order one nibble per grant, first grant in bits [3:0].
  task automatic check_order(input string tag, input int n, input logic [31:0] seq);
    chk({tag, "_ngrants"}, grants.size(), n);
    for (int k = 0; k < n && k < grants.size(); k++) chk({tag, "_grant"}, grants[k], (seq >> (4 * k)) & 32'hF);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_ = 1'b0;
    flush();
    #3;
    chk("rst_tx_req", tx_req, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    do_reset();

    push_byte(0, 8'h48, 1'b0);
    push_byte(0, 8'h65, 1'b1);
    drain("hello");
    check_order("hello", 1, 32'h0);

    do_reset();
    push_pkt(0, 3);
    push_pkt(1, 3);
    drain("contention");
    check_order("contention", 2, 32'h10);

    do_reset();
    for (int p = 0; p < 3; p++) push_pkt(0, 1);
    push_pkt(1, 1);
    drain("fairness");
    check_order("fairness", 4, 32'h0010);

    do_reset();
    rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    push_pkt(0, 4);
    drain("backpressure");
    check_order("backpressure", 1, 32'h0);

    do_reset();
    push_pkt(0, 6);
    drain("maxpkt_solo");
    check_order("maxpkt_solo", 2, 32'h00);

    do_reset();
    push_pkt(0, 6);
    push_pkt(1, 1);
    drain("maxpkt_shared");
    check_order("maxpkt_shared", 3, 32'h010);

    do_reset();
    push_pkt(0, 5);
    for (int c = 0; c < 20 && n_xfer < 2; c++) step();
    chk("midrst_progress", n_xfer, 2);
    #2 reset_ = 1'b0;
    #1;
    chk("midrst_tx_req", tx_req, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_req_ready", req_ready, 0);
    flush();
    @(negedge clk);
    reset_ = 1'b1;
    push_pkt(1, 2);
    push_pkt(0, 2);
    drain("midrst_after");
    check_order("midrst_after", 2, 32'h10);

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    do_reset();
    push_pkt(0, 2);
    for (int c = 0; c < 20 && n_xfer < 1; c++) step();
    dens = 0;
    repeat (TMO + 4) step();
    chk("timeout_pulses", n_evt, 1);
    chk("timeout_busy", busy, 0);
    dens = 100;
    drain("timeout_after");
    check_order("timeout_after", 2, 32'h00);
`endif

    do_reset();
    dens     = 60;
    rdy_dens = 70;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NUM; i++)
        if (dq_dat[i].size() < 4 && $urandom_range(99) < 15) push_pkt(i, $urandom_range(1, 6));
      step();
    end
    dens = 100;
    drain("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
